vga_scanout: RTL and testbench

- Read side of the painter frame buffers. The painter writes pixels into the red/green/blue 1-bit block RAMs; this block reads them back on their port B.
- Generates 640x480@60 VGA timing from the system clock using a pixel-enable divider.
- Issues frame-buffer read addresses at the downscaled resolution and drives registered hsync/vsync/RGB to the DAC pins.
- Emits a vertical-blank strobe that the draw unit uses for frame pacing.

---
 rtl/vga_scanout.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: read side of the painter frame buffers.
// Produces 640x480@60 VGA timing from the system clock via a pixel-enable
// divider, issues downscaled frame-buffer read addresses, and drives
// registered hsync/vsync/RGB plus vblank and a vblank_start strobe.
// Optional feature macro: SPECIAL_OVERLAY_EN adds sp_addr/sp_data; a nonzero
// special-buffer pixel overrides the R/G/B buffers inside the visible window.
module vga_scanout #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_W        = 160,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic              fb_r,
  input  logic              fb_g,
  input  logic              fb_b,
  output logic              hsync,
  output logic              vsync,
  output logic              red,
  output logic              green,
  output logic              blue,
  output logic              vblank,
  output logic              vblank_start
`ifdef SPECIAL_OVERLAY_EN
  ,
  output logic [10:0]       sp_addr,
  input  logic [2:0]        sp_data
`endif
);

  localparam int unsigned H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W       = $clog2(H_TOTAL);
  localparam int unsigned V_W       = $clog2(V_TOTAL);
  localparam int unsigned DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_START  = H_VIS + H_FP;
  localparam int unsigned HS_END    = H_VIS + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_VIS + V_FP;
  localparam int unsigned VS_END    = V_VIS + V_FP + V_SYNC;
  localparam int unsigned ROW_LINES = 1 << SCALE_SHIFT;

  logic [DIV_W-1:0]  divCnt;
  logic              pixEn;
  logic [H_W-1:0]    hCnt;
  logic [H_W-1:0]    hNext;
  logic [V_W-1:0]    vCnt;
  logic [V_W-1:0]    vNext;
  logic              hWrap;
  logic              vWrap;
  logic [31:0]       vInc;
  logic              rowStep;
  logic              lineVis;
  logic              hsRaw;
  logic              vsRaw;
  logic [ADDR_W-1:0] rowBase;
  logic [ADDR_W-1:0] addrNext;
  logic              vbStartNext;
  logic              visD;
  logic              hsRawD;
  logic              vsRawD;
  logic [2:0]        pixColour;

  // Next-state decode for the divider, raster counters and address stepping.
  always_comb begin
    pixEn       = (divCnt == DIV_W'(CLK_DIV - 1));
    hWrap       = (32'(hCnt) == H_TOTAL - 1);
    vWrap       = (32'(vCnt) == V_TOTAL - 1);
    hNext       = hWrap ? '0 : hCnt + H_W'(1);
    vNext       = vCnt;
    if (hWrap) begin
      vNext = vWrap ? '0 : vCnt + V_W'(1);
    end
    vInc        = 32'(vCnt) + 32'd1;
    rowStep     = hWrap && ((vInc & (ROW_LINES - 1)) == 32'd0) && (vInc < V_VIS);
    lineVis     = (32'(hCnt) < H_VIS) && (32'(vCnt) < V_VIS);
    hsRaw       = !((32'(hCnt) >= HS_START) && (32'(hCnt) < HS_END));
    vsRaw       = !((32'(vCnt) >= VS_START) && (32'(vCnt) < VS_END));
    addrNext    = rowBase + ADDR_W'(hCnt >> SCALE_SHIFT);
    vbStartNext = pixEn && hWrap && (32'(vCnt) == V_VIS - 1);
  end

  // Pixel-enable divider: one pixel tick every CLK_DIV system clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt <= '0;
    end else if (pixEn) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixEn) begin
      hCnt <= hNext;
      vCnt <= vNext;
    end
  end

  // Frame-buffer address: row base steps by FB_W every 2^SCALE_SHIFT lines,
  // and the address holds its last visible value through blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowBase <= '0;
      fb_addr <= '0;
    end else if (pixEn) begin
      if (lineVis) begin
        fb_addr <= addrNext;
      end
      if (hWrap && vWrap) begin
        rowBase <= '0;
      end else if (rowStep) begin
        rowBase <= rowBase + ADDR_W'(FB_W);
      end
    end
  end

`ifdef SPECIAL_OVERLAY_EN
  localparam int unsigned SP_W     = 11;
  localparam int unsigned SP_PITCH = 40;
  localparam int unsigned SP_SHIFT = 4;
  localparam int unsigned SP_LINES = 1 << SP_SHIFT;

  logic [SP_W-1:0] spRowBase;
  logic            spStep;

  assign spStep = hWrap && ((vInc & (SP_LINES - 1)) == 32'd0) && (vInc < V_VIS);

  // Special-buffer address: 16x16 tiles, 40 tiles per row, same hold rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      spRowBase <= '0;
      sp_addr   <= '0;
    end else if (pixEn) begin
      if (lineVis) begin
        sp_addr <= spRowBase + SP_W'(hCnt >> SP_SHIFT);
      end
      if (hWrap && vWrap) begin
        spRowBase <= '0;
      end else if (spStep) begin
        spRowBase <= spRowBase + SP_W'(SP_PITCH);
      end
    end
  end
`endif

  // Stage 1: visibility and raw sync levels aligned with the issued address.
  always_ff @(posedge clk) begin
    if (reset) begin
      visD   <= 1'b0;
      hsRawD <= 1'b1;
      vsRawD <= 1'b1;
    end else if (pixEn) begin
      visD   <= lineVis;
      hsRawD <= hsRaw;
      vsRawD <= vsRaw;
    end
  end

  // Pixel colour select; blanked outside the visible window.
  always_comb begin
    pixColour = {fb_r, fb_g, fb_b};
`ifdef SPECIAL_OVERLAY_EN
    if (sp_data != 3'b000) begin
      pixColour = sp_data;
    end
`endif
    if (!visD) begin
      pixColour = 3'b000;
    end
  end

  // Stage 2: registered pins, sync and colour from the same raster position.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else if (pixEn) begin
      hsync <= hsRawD;
      vsync <= vsRawD;
      {red, green, blue} <= pixColour;
    end
  end

  // Vertical blank level follows the line the counters are moving to.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank <= 1'b0;
    end else if (pixEn) begin
      vblank <= (32'(vNext) >= V_VIS);
    end
  end

  // One-clock strobe on the edge where the counter enters line V_VIS.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_start <= 1'b0;
    end else begin
      vblank_start <= vbStartNext;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout.
// Instance A uses the default 640x480 timing with RAM data = address bits;
// instance B uses a reduced raster, CLK_DIV=4, all-ones RAM data and a
// mid-frame reset. Expected pins come from a position-based raster model.
`timescale 1ns/1ps
module tb_vga_scanout;

  typedef struct {
    int hVis; int hFp; int hSync; int hBp;
    int vVis; int vFp; int vSync; int vBp;
    int shift; int fbw; int clkDiv;
    bit allOnes;
  } cfg_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic        vb;
    logic        vbs;
  } exp_t;

  typedef struct {
    exp_t e;
    int   k;
    bit   pix;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit doneA = 1'b0;
  bit doneB = 1'b0;
  ent_t qA[$];
  ent_t qB[$];

  // Instance A signals
  logic        rstA;
  logic [15:0] fbAddrA;
  logic        fbRA, fbGA, fbBA;
  logic        hsyncA, vsyncA, redA, greenA, blueA, vblankA, vblankStartA;
  // Instance B signals
  logic        rstB;
  logic [15:0] fbAddrB;
  logic        fbOnes;
  logic        hsyncB, vsyncB, redB, greenB, blueB, vblankB, vblankStartB;
`ifdef SPECIAL_OVERLAY_EN
  logic [10:0] spAddrA, spAddrB;
  logic [2:0]  spDataA, spDataB;
`endif

  vga_scanout dutA (
    .clk(clk), .reset(rstA), .fb_addr(fbAddrA),
    .fb_r(fbRA), .fb_g(fbGA), .fb_b(fbBA),
    .hsync(hsyncA), .vsync(vsyncA), .red(redA), .green(greenA), .blue(blueA),
    .vblank(vblankA), .vblank_start(vblankStartA)
`ifdef SPECIAL_OVERLAY_EN
    , .sp_addr(spAddrA), .sp_data(spDataA)
`endif
  );

  vga_scanout #(
    .CLK_DIV(4), .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SCALE_SHIFT(2), .FB_W(8), .ADDR_W(16)
  ) dutB (
    .clk(clk), .reset(rstB), .fb_addr(fbAddrB),
    .fb_r(fbOnes), .fb_g(fbOnes), .fb_b(fbOnes),
    .hsync(hsyncB), .vsync(vsyncB), .red(redB), .green(greenB), .blue(blueB),
    .vblank(vblankB), .vblank_start(vblankStartB)
`ifdef SPECIAL_OVERLAY_EN
    , .sp_addr(spAddrB), .sp_data(spDataB)
`endif
  );

  // One-clock-latency buffer RAM models
  always @(posedge clk) begin
    fbRA <= fbAddrA[0];
    fbGA <= fbAddrA[1];
    fbBA <= fbAddrA[2];
`ifdef SPECIAL_OVERLAY_EN
    spDataA <= (spAddrA == 11'd41) ? 3'b101 : 3'b000;
    spDataB <= (spAddrB == 11'd41) ? 3'b101 : 3'b000;
`endif
  end

  function automatic cfg_t cfgA();
    cfg_t c;
    c.hVis = 640; c.hFp = 16; c.hSync = 96; c.hBp = 48;
    c.vVis = 480; c.vFp = 10; c.vSync = 2;  c.vBp = 33;
    c.shift = 2; c.fbw = 160; c.clkDiv = 2; c.allOnes = 1'b0;
    return c;
  endfunction

  function automatic cfg_t cfgB();
    cfg_t c;
    c.hVis = 32; c.hFp = 4; c.hSync = 8; c.hBp = 4;
    c.vVis = 16; c.vFp = 2; c.vSync = 2; c.vBp = 3;
    c.shift = 2; c.fbw = 8; c.clkDiv = 4; c.allOnes = 1'b1;
    return c;
  endfunction

  function automatic int hTot(input cfg_t c);
    return c.hVis + c.hFp + c.hSync + c.hBp;
  endfunction

  function automatic int vTot(input cfg_t c);
    return c.vVis + c.vFp + c.vSync + c.vBp;
  endfunction

  function automatic int posH(input cfg_t c, input int i);
    return (i % (hTot(c) * vTot(c))) % hTot(c);
  endfunction

  function automatic int posV(input cfg_t c, input int i);
    return (i % (hTot(c) * vTot(c))) / hTot(c);
  endfunction

  function automatic bit isVis(input cfg_t c, input int h, input int v);
    return (h < c.hVis) && (v < c.vVis);
  endfunction

  function automatic int addrOf(input cfg_t c, input int h, input int v);
    return (v >> c.shift) * c.fbw + (h >> c.shift);
  endfunction

  function automatic logic [2:0] colourOf(input cfg_t c, input int a);
    logic [15:0] av;
    av = 16'(a);
    return c.allOnes ? 3'b111 : {av[0], av[1], av[2]};
  endfunction

  // Expected outputs right after pixel tick k (k >= 1) since reset release.
  function automatic exp_t pixEntry(input cfg_t c, input int k, input logic [15:0] holdAddr);
    exp_t e;
    int h, v;
    h = posH(c, k - 1);
    v = posV(c, k - 1);
    e.addr = isVis(c, h, v) ? 16'(addrOf(c, h, v)) : holdAddr;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.rgb = 3'b000;
    if (k >= 2) begin
      h = posH(c, k - 2);
      v = posV(c, k - 2);
      e.hs = !((h >= c.hVis + c.hFp) && (h < c.hVis + c.hFp + c.hSync));
      e.vs = !((v >= c.vVis + c.vFp) && (v < c.vVis + c.vFp + c.vSync));
      if (isVis(c, h, v)) begin
        e.rgb = colourOf(c, addrOf(c, h, v));
`ifdef SPECIAL_OVERLAY_EN
        if (((v >> 4) * 40 + (h >> 4)) == 41) e.rgb = 3'b101;
`endif
      end
    end
    h = posH(c, k);
    v = posV(c, k);
    e.vb  = (v >= c.vVis);
    e.vbs = (h == 0) && (v == c.vVis);
    return e;
  endfunction

  task automatic stepModel(input cfg_t c, input bit rst, inout int clkCnt, inout ent_t ent);
    if (rst) begin
      clkCnt     = 0;
      ent.k      = 0;
      ent.pix    = 1'b0;
      ent.e.addr = 16'd0;
      ent.e.hs   = 1'b1;
      ent.e.vs   = 1'b1;
      ent.e.rgb  = 3'b000;
      ent.e.vb   = 1'b0;
      ent.e.vbs  = 1'b0;
    end else begin
      clkCnt++;
      if (clkCnt % c.clkDiv == 0) begin
        ent.k   = clkCnt / c.clkDiv;
        ent.pix = 1'b1;
        ent.e   = pixEntry(c, ent.k, ent.e.addr);
      end else begin
        ent.pix   = 1'b0;
        ent.e.vbs = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Hand-computed spot values for the default-timing instance
  task automatic directedA(input int k);
    case (k)
      1:    check("A.addr_h0", 32'(fbAddrA), 32'd0);
      2:    check("A.rgb_h0", 32'({redA, greenA, blueA}), 32'd0);
      5:    check("A.addr_h4", 32'(fbAddrA), 32'd1);
      6:    check("A.rgb_h4", 32'({redA, greenA, blueA}), 32'b100);
      30:   check("A.rgb_h28", 32'({redA, greenA, blueA}), 32'b111);
      640:  check("A.addr_h639", 32'(fbAddrA), 32'd159);
      642: begin
        check("A.addr_hold", 32'(fbAddrA), 32'd159);
        check("A.rgb_blank_h640", 32'({redA, greenA, blueA}), 32'd0);
      end
      657:  check("A.hsync_pre", 32'(hsyncA), 32'd1);
      658:  check("A.hsync_fall", 32'(hsyncA), 32'd0);
      753:  check("A.hsync_last_low", 32'(hsyncA), 32'd0);
      754:  check("A.hsync_rise", 32'(hsyncA), 32'd1);
      801:  check("A.addr_line1", 32'(fbAddrA), 32'd0);
      3201: check("A.addr_line4", 32'(fbAddrA), 32'd160);
      default: ;
    endcase
  endtask

  // Hand-computed spot values for the reduced-timing instance
  task automatic directedB(input int k);
    case (k)
      2:   check("B.rgb_0_0", 32'({redB, greenB, blueB}), 32'b111);
      32:  check("B.addr_h31", 32'(fbAddrB), 32'd7);
      33:  check("B.rgb_h31", 32'({redB, greenB, blueB}), 32'b111);
      34:  check("B.rgb_h32", 32'({redB, greenB, blueB}), 32'd0);
      193: check("B.addr_line4", 32'(fbAddrB), 32'd8);
      752: check("B.addr_last", 32'(fbAddrB), 32'd31);
      767: check("B.vbs_pre", 32'({vblankB, vblankStartB}), 32'b00);
      768: check("B.vbs_pulse", 32'({vblankB, vblankStartB}), 32'b11);
      865: check("B.vsync_pre", 32'(vsyncB), 32'd1);
      866: check("B.vsync_fall", 32'(vsyncB), 32'd0);
      default: ;
    endcase
  endtask

  // Monitor: pop one expectation per instance each clock and compare.
  always @(negedge clk) begin : monitor
    ent_t ea;
    ent_t eb;
    if (qA.size() > 0) begin
      ea = qA.pop_front();
      check("A.fb_addr", 32'(fbAddrA), 32'(ea.e.addr));
      check("A.sync", 32'({hsyncA, vsyncA}), 32'({ea.e.hs, ea.e.vs}));
      check("A.rgb", 32'({redA, greenA, blueA}), 32'(ea.e.rgb));
      check("A.vblank", 32'({vblankA, vblankStartA}), 32'({ea.e.vb, ea.e.vbs}));
      if (ea.pix) directedA(ea.k);
    end
    if (qB.size() > 0) begin
      eb = qB.pop_front();
      check("B.fb_addr", 32'(fbAddrB), 32'(eb.e.addr));
      check("B.sync", 32'({hsyncB, vsyncB}), 32'({eb.e.hs, eb.e.vs}));
      check("B.rgb", 32'({redB, greenB, blueB}), 32'(eb.e.rgb));
      check("B.vblank", 32'({vblankB, vblankStartB}), 32'({eb.e.vb, eb.e.vbs}));
      if (eb.pix) directedB(eb.k);
    end
  end

  // Instance A: reset, then the first 3400 pixel ticks at CLK_DIV=2.
  initial begin : stimA
    cfg_t c;
    int clkCnt;
    ent_t ent;
    c = cfgA();
    clkCnt = 0;
    ent.k = 0;
    ent.pix = 1'b0;
    ent.e = '0;
    rstA = 1'b1;
    repeat (3) begin
      @(posedge clk);
      stepModel(c, 1'b1, clkCnt, ent);
      qA.push_back(ent);
    end
    @(negedge clk);
    rstA = 1'b0;
    repeat (3400 * 2) begin
      @(posedge clk);
      stepModel(c, 1'b0, clkCnt, ent);
      qA.push_back(ent);
    end
    doneA = 1'b1;
  end

  // Instance B: two frames, one-clock reset at (h=20, v=10), then a frame more.
  initial begin : stimB
    cfg_t c;
    int clkCnt;
    ent_t ent;
    c = cfgB();
    clkCnt = 0;
    ent.k = 0;
    ent.pix = 1'b0;
    ent.e = '0;
    fbOnes = 1'b1;
    rstB = 1'b1;
    repeat (3) begin
      @(posedge clk);
      stepModel(c, 1'b1, clkCnt, ent);
      qB.push_back(ent);
    end
    @(negedge clk);
    rstB = 1'b0;
    repeat ((2 * 1104 + 500) * 4 + 2) begin
      @(posedge clk);
      stepModel(c, 1'b0, clkCnt, ent);
      qB.push_back(ent);
    end
    @(negedge clk);
    rstB = 1'b1;
    @(posedge clk);
    stepModel(c, 1'b1, clkCnt, ent);
    qB.push_back(ent);
    @(negedge clk);
    rstB = 1'b0;
    repeat ((1104 + 100) * 4) begin
      @(posedge clk);
      stepModel(c, 1'b0, clkCnt, ent);
      qB.push_back(ent);
    end
    doneB = 1'b1;
  end

  // Wait for both stimulus streams, let the monitor drain, then summarise.
  initial begin : finisher
    int waited;
    waited = 0;
    while (!(doneA && doneB) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (!(doneA && doneB)) begin
      $display("FAIL watchdog: stimulus incomplete after %0d clocks", waited);
      $fatal(1, "watchdog expired");
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
